// File: rtl/prt_dp_pm_pkg.sv
// Shared definitions for the policy-maker memory loader: FSM states,
// error-bit and valid-bit indices.
package prt_dp_pm_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } ldr_state_t;

  localparam int unsigned P_ERR_ROM_OF  = 0;
  localparam int unsigned P_ERR_RAM_OF  = 1;
  localparam int unsigned P_ERR_PROT    = 2;

  localparam int unsigned P_MEM_VLD_ROM = 0;
  localparam int unsigned P_MEM_VLD_RAM = 1;

endpackage

// File: rtl/prt_dp_pm_mem_ldr_cnt.sv
// Saturating word counter for one target memory: counts 0..2**P_ADR and
// flags full when the memory depth has been reached.
module prt_dp_pm_mem_ldr_cnt #(
  parameter int unsigned P_ADR = 10
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [P_ADR:0]   cnt_o,
  output logic [P_ADR-1:0] adr_o,
  output logic             full_o
);

  localparam logic [P_ADR:0] DEPTH = {1'b1, {P_ADR{1'b0}}};

  logic [P_ADR:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != DEPTH)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o  = cnt_q;
  assign adr_o  = cnt_q[P_ADR-1:0];
  assign full_o = (cnt_q == DEPTH);

endmodule

// File: rtl/prt_dp_pm_mem_ldr.sv
// Policy-maker memory loader: turns the exchange block's update stream into
// sequential ROM/RAM writes. Checksum enabled by PRT_DP_PM_MEM_LDR_CHK_EN.
module prt_dp_pm_mem_ldr
  import prt_dp_pm_pkg::*;
#(
  parameter int unsigned P_ROM_ADR = 12,
  parameter int unsigned P_RAM_ADR = 10,
  parameter int unsigned P_TMO     = 255
) (
  input  logic                 CLK_IN,
  input  logic                 RST_IN,
  input  logic                 MEM_STR_IN,
  input  logic [31:0]          MEM_DAT_IN,
  input  logic [1:0]           MEM_VLD_IN,
  output logic                 ROM_WR_OUT,
  output logic [P_ROM_ADR-1:0] ROM_ADR_OUT,
  output logic [31:0]          ROM_DAT_OUT,
  output logic                 RAM_WR_OUT,
  output logic [P_RAM_ADR-1:0] RAM_ADR_OUT,
  output logic [31:0]          RAM_DAT_OUT,
  output logic                 BUSY_OUT,
  output logic                 DONE_OUT,
  output logic [P_ROM_ADR:0]   ROM_WRDS_OUT,
  output logic [P_RAM_ADR:0]   RAM_WRDS_OUT,
  output logic [2:0]           ERR_OUT,
  output logic [31:0]          CHK_OUT
);

  localparam logic [15:0] TMO_MAX  = 16'(P_TMO);
  localparam logic [15:0] TMO_LAST = 16'(P_TMO - 1);

  ldr_state_t             state_q;
  logic [15:0]            tmo_q;
  logic                   rom_wr_q, ram_wr_q, done_q;
  logic [P_ROM_ADR-1:0]   rom_adr_q, rom_cnt_adr;
  logic [P_RAM_ADR-1:0]   ram_adr_q, ram_cnt_adr;
  logic [31:0]            rom_dat_q, ram_dat_q;
  logic [2:0]             err_q, err_d;
  logic                   rom_full, ram_full;
  logic                   in_load, vld_any, vld_rom, vld_ram, vld_both;
  logic                   rom_acc, ram_acc, tmo_hit;

  always_comb begin
    in_load  = (state_q == ST_LOAD);
    vld_any  = |MEM_VLD_IN;
    vld_rom  =  MEM_VLD_IN[P_MEM_VLD_ROM] & ~MEM_VLD_IN[P_MEM_VLD_RAM];
    vld_ram  = ~MEM_VLD_IN[P_MEM_VLD_ROM] &  MEM_VLD_IN[P_MEM_VLD_RAM];
    vld_both =  MEM_VLD_IN[P_MEM_VLD_ROM] &  MEM_VLD_IN[P_MEM_VLD_RAM];
    rom_acc  = ~MEM_STR_IN & in_load & vld_rom & ~rom_full;
    ram_acc  = ~MEM_STR_IN & in_load & vld_ram & ~ram_full;
    // Leave LOAD on the edge where the idle count would reach P_TMO.
    tmo_hit  = ~MEM_STR_IN & in_load & ~vld_any & (tmo_q >= TMO_LAST);

    err_d = err_q;
    if (MEM_STR_IN) begin
      err_d             = '0;
      err_d[P_ERR_PROT] = vld_any;
    end else if (in_load) begin
      if (vld_rom && rom_full) err_d[P_ERR_ROM_OF] = 1'b1;
      if (vld_ram && ram_full) err_d[P_ERR_RAM_OF] = 1'b1;
      if (vld_both)            err_d[P_ERR_PROT]   = 1'b1;
    end else if (vld_any) begin
      err_d[P_ERR_PROT] = 1'b1;
    end
  end

  prt_dp_pm_mem_ldr_cnt #(.P_ADR(P_ROM_ADR)) u_rom_cnt (
    .clk_i   (CLK_IN),
    .rst_n_i (RST_IN),
    .clr_i   (MEM_STR_IN),
    .inc_i   (rom_acc),
    .cnt_o   (ROM_WRDS_OUT),
    .adr_o   (rom_cnt_adr),
    .full_o  (rom_full)
  );

  prt_dp_pm_mem_ldr_cnt #(.P_ADR(P_RAM_ADR)) u_ram_cnt (
    .clk_i   (CLK_IN),
    .rst_n_i (RST_IN),
    .clr_i   (MEM_STR_IN),
    .inc_i   (ram_acc),
    .cnt_o   (RAM_WRDS_OUT),
    .adr_o   (ram_cnt_adr),
    .full_o  (ram_full)
  );

  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      state_q   <= ST_IDLE;
      tmo_q     <= '0;
      rom_wr_q  <= 1'b0;
      ram_wr_q  <= 1'b0;
      done_q    <= 1'b0;
      rom_adr_q <= '0;
      ram_adr_q <= '0;
      rom_dat_q <= '0;
      ram_dat_q <= '0;
      err_q     <= '0;
    end else begin
      rom_wr_q <= rom_acc;
      ram_wr_q <= ram_acc;
      done_q   <= tmo_hit;
      err_q    <= err_d;
      if (rom_acc) begin
        rom_adr_q <= rom_cnt_adr;
        rom_dat_q <= MEM_DAT_IN;
      end
      if (ram_acc) begin
        ram_adr_q <= ram_cnt_adr;
        ram_dat_q <= MEM_DAT_IN;
      end
      if (MEM_STR_IN) begin
        state_q <= ST_LOAD;
        tmo_q   <= '0;
      end else if (in_load) begin
        if (vld_any) begin
          tmo_q <= '0;
        end else if (tmo_hit) begin
          tmo_q   <= TMO_MAX;
          state_q <= ST_IDLE;
        end else begin
          tmo_q <= tmo_q + 16'd1;
        end
      end
    end
  end

`ifdef PRT_DP_PM_MEM_LDR_CHK_EN
  logic [31:0] chk_q;

  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      chk_q <= '0;
    end else if (MEM_STR_IN) begin
      chk_q <= '0;
    end else if (rom_acc || ram_acc) begin
      chk_q <= chk_q + MEM_DAT_IN;
    end
  end

  assign CHK_OUT = chk_q;
`else
  assign CHK_OUT = '0;
`endif

  assign ROM_WR_OUT  = rom_wr_q;
  assign ROM_ADR_OUT = rom_adr_q;
  assign ROM_DAT_OUT = rom_dat_q;
  assign RAM_WR_OUT  = ram_wr_q;
  assign RAM_ADR_OUT = ram_adr_q;
  assign RAM_DAT_OUT = ram_dat_q;
  assign BUSY_OUT    = in_load;
  assign DONE_OUT    = done_q;
  assign ERR_OUT     = err_q;

endmodule

// File: tb/tb_prt_dp_pm_mem_ldr.sv
// Scoreboard bench for prt_dp_pm_mem_ldr (RAM shrunk to 4 words for overflow).
module tb_prt_dp_pm_mem_ldr;

  localparam int unsigned ROM_A = 12;
  localparam int unsigned RAM_A = 2;
`ifdef PRT_DP_PM_MEM_LDR_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             str;
  logic [31:0]      dat;
  logic [1:0]       vld;
  logic             rom_wr, ram_wr, busy, done;
  logic [ROM_A-1:0] rom_adr;
  logic [RAM_A-1:0] ram_adr;
  logic [31:0]      rom_dat, ram_dat, chk_o;
  logic [ROM_A:0]   rom_wrds;
  logic [RAM_A:0]   ram_wrds;
  logic [2:0]       err;

  typedef struct {
    bit          is_ram;
    logic [15:0] adr;
    logic [31:0] dat;
  } wr_t;

  wr_t exp_q[$];
  int  vectors    = 0;
  int  miscompares = 0;
  int  done_cnt   = 0;

  always #5 clk = ~clk;

  prt_dp_pm_mem_ldr #(.P_ROM_ADR(ROM_A), .P_RAM_ADR(RAM_A), .P_TMO(255)) dut (
    .CLK_IN       (clk),
    .RST_IN       (rst_n),
    .MEM_STR_IN   (str),
    .MEM_DAT_IN   (dat),
    .MEM_VLD_IN   (vld),
    .ROM_WR_OUT   (rom_wr),
    .ROM_ADR_OUT  (rom_adr),
    .ROM_DAT_OUT  (rom_dat),
    .RAM_WR_OUT   (ram_wr),
    .RAM_ADR_OUT  (ram_adr),
    .RAM_DAT_OUT  (ram_dat),
    .BUSY_OUT     (busy),
    .DONE_OUT     (done),
    .ROM_WRDS_OUT (rom_wrds),
    .RAM_WRDS_OUT (ram_wrds),
    .ERR_OUT      (err),
    .CHK_OUT      (chk_o)
  );

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic void mon(input bit is_ram, input logic [15:0] a, input logic [31:0] d);
    wr_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_wr: got %s write adr %0h dat %0h, expected none (t=%0t)",
               is_ram ? "RAM" : "ROM", a, d, $time);
    end else begin
      e = exp_q.pop_front();
      chk("wr_sel", 64'(is_ram), 64'(e.is_ram));
      chk("wr_adr", 64'(a), 64'(e.adr));
      chk("wr_dat", 64'(d), 64'(e.dat));
    end
  endfunction

  always @(negedge clk) begin
    if (rom_wr) mon(1'b0, 16'(rom_adr), rom_dat);
    if (ram_wr) mon(1'b1, 16'(ram_adr), ram_dat);
    if (done)   done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    str = 1'b1;
    tick();
    str = 1'b0;
  endtask

  task automatic send(input logic [1:0] v, input logic [31:0] d);
    vld = v;
    dat = d;
    tick();
    vld = 2'b00;
  endtask

  task automatic expect_wr(input bit r, input int a, input logic [31:0] d);
    wr_t e;
    e.is_ram = r;
    e.adr    = 16'(a);
    e.dat    = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (busy && n < 1000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int d0;
    rst_n = 1'b0;
    str   = 1'b0;
    vld   = 2'b00;
    dat   = '0;
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_rom_wrds", 64'(rom_wrds), 0);
    chk("rst_ram_wrds", 64'(ram_wrds), 0);
    chk("rst_outs", 64'({rom_wr, ram_wr, rom_adr, ram_adr}), 0);
    chk("rst_dat", 64'({rom_dat, ram_dat}), 0);
    chk("rst_chk", 64'(chk_o), 0);
    rst_n = 1'b1;
    tick();

    // Four ROM words, then idle until the timeout ends the load.
    start();
    chk("t1_busy", 64'(busy), 1);
    expect_wr(0, 0, 32'h11); expect_wr(0, 1, 32'h22);
    expect_wr(0, 2, 32'h33); expect_wr(0, 3, 32'h44);
    send(2'b01, 32'h11); send(2'b01, 32'h22);
    send(2'b01, 32'h33); send(2'b01, 32'h44);
    chk("t1_rom_wrds", 64'(rom_wrds), 4);
    d0 = done_cnt;
    wait_done(n);
    chk("t1_idle_cycles", 64'(n), 255);
    chk("t1_done_pulse", 64'(done), 1);
    chk("t1_busy_low", 64'(busy), 0);
    tick();
    chk("t1_done_low", 64'(done), 0);
    chk("t1_done_cnt", 64'(done_cnt - d0), 1);
    chk("t1_rom_wrds_hold", 64'(rom_wrds), 4);
    chk("t1_rom_dat_hold", 64'(rom_dat), 32'h44);
    chk("t1_err", 64'(err), 0);

    // Interleaved ROM/RAM.
    start();
    expect_wr(0, 0, 32'hA000_0001); expect_wr(1, 0, 32'h0B00_0002);
    expect_wr(0, 1, 32'h00C0_0003); expect_wr(1, 1, 32'h000D_0004);
    send(2'b01, 32'hA000_0001); send(2'b10, 32'h0B00_0002);
    send(2'b01, 32'h00C0_0003); send(2'b10, 32'h000D_0004);
    chk("t2_err", 64'(err), 0);
    chk("t2_rom_wrds", 64'(rom_wrds), 2);
    chk("t2_ram_wrds", 64'(ram_wrds), 2);
    chk("t2_chk", 64'(chk_o), CHK_EN ? 64'h0000_0000_ABCD_000A : 64'h0);

    // RAM overflow at depth 4.
    start();
    chk("t3_cleared", 64'({err, rom_wrds, ram_wrds}), 0);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) expect_wr(1, i, 32'h100 + 32'(i));
      send(2'b10, 32'h100 + 32'(i));
    end
    chk("t3_err", 64'(err), 3'b010);
    chk("t3_ram_wrds", 64'(ram_wrds), 4);
    chk("t3_chk", 64'(chk_o), CHK_EN ? 64'h406 : 64'h0);

    // Protocol errors: both valids in LOAD, then a valid in IDLE.
    start();
    send(2'b11, 32'hDEAD_BEEF);
    chk("t4_err", 64'(err), 3'b100);
    wait_done(n);
    chk("t4_idle_cycles", 64'(n), 255);
    send(2'b01, 32'hBAD0_0001);
    tick();
    chk("t4_err_idle", 64'(err), 3'b100);
    chk("t4_counts", 64'({rom_wrds, ram_wrds}), 0);
    chk("t4_busy", 64'(busy), 0);

    // Restart mid-load.
    start();
    expect_wr(0, 0, 32'h1); expect_wr(0, 1, 32'h2); expect_wr(0, 2, 32'h3);
    send(2'b01, 32'h1); send(2'b01, 32'h2); send(2'b01, 32'h3);
    send(2'b11, 32'h0);
    chk("t5_pre_err", 64'(err), 3'b100);
    d0 = done_cnt;
    start();
    chk("t5_rom_wrds", 64'(rom_wrds), 0);
    chk("t5_err", 64'(err), 0);
    chk("t5_chk_clr", 64'(chk_o), 0);
    expect_wr(0, 0, 32'h55);
    send(2'b01, 32'h55);
    tick();
    chk("t5_chk", 64'(chk_o), CHK_EN ? 64'h55 : 64'h0);
    chk("t5_no_done", 64'(done_cnt - d0), 0);
    chk("t5_busy", 64'(busy), 1);

    // Start with a valid in the same cycle: data dropped, error kept.
    str = 1'b1; vld = 2'b01; dat = 32'h77;
    tick();
    str = 1'b0; vld = 2'b00;
    tick();
    chk("t6_err", 64'(err), 3'b100);
    chk("t6_rom_wrds", 64'(rom_wrds), 0);

    // Asynchronous reset mid-load.
    expect_wr(0, 0, 32'h99);
    send(2'b01, 32'h99);
    tick();
    #3 rst_n = 1'b0;
    #1;
    chk("t7_busy", 64'(busy), 0);
    chk("t7_outs", 64'({rom_wr, ram_wr, done, err, rom_adr, ram_adr}), 0);
    chk("t7_dat", 64'({rom_dat, ram_dat}), 0);
    chk("t7_counts", 64'({rom_wrds, ram_wrds}), 0);
    chk("t7_chk", 64'(chk_o), 0);
    tick();
    rst_n = 1'b1;
    tick();
    send(2'b01, 32'hABCD);
    tick();
    chk("t7_err_after", 64'(err), 3'b100);
    chk("t7_rom_wrds_after", 64'(rom_wrds), 0);
    chk("t7_busy_after", 64'(busy), 0);

    repeat (2) tick();
    chk("exp_q_empty", 64'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
